// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: machine word and the buffered instruction entry.
package fetch_queue_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
    word_t pred_pc;
    logic  pred_taken;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode side signals of the fetch queue; master is the fetch+decode pair, slave is the queue.
interface fetch_queue_if #(parameter int DEPTH = 4);
  import fetch_queue_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready. Both sides are
  // registered-state driven; enq_ready never depends combinationally on deq_ready.
  logic          enq_valid;
  logic          enq_ready;
  word_t         enq_pc;
  word_t         enq_instr;
  word_t         enq_pred_pc;
  logic          enq_pred_taken;
  logic          flush;
  logic          deq_valid;
  logic          deq_ready;
  word_t         deq_pc;
  word_t         deq_instr;
  word_t         deq_pred_pc;
  logic          deq_pred_taken;
  logic [CW-1:0] count;
  logic          freeze;

  modport master (
    output enq_valid, enq_pc, enq_instr, enq_pred_pc, enq_pred_taken, flush, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_instr, deq_pred_pc, deq_pred_taken, count, freeze
  );

  modport slave (
    input  enq_valid, enq_pc, enq_instr, enq_pred_pc, enq_pred_taken, flush, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_instr, deq_pred_pc, deq_pred_taken, count, freeze
  );

endinterface

// File: rtl/fetch_queue.sv
// In-order instruction queue between fetch and decode with misprediction flush.
// Optional zero-latency empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic         CLK,
  input logic         nRST,
  fetch_queue_if.slave fq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fq_entry_t     mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;

  fq_entry_t enq_e;
  fq_entry_t head_e;
  logic      empty;
  logic      ready;
  logic      bypass;
  logic      enq_fire;
  logic      deq_fire;

  assign enq_e = '{pc: fq.enq_pc, instr: fq.enq_instr,
                   pred_pc: fq.enq_pred_pc, pred_taken: fq.enq_pred_taken};

  assign empty = (cnt == '0);
  assign ready = (cnt != FULL_CNT);

  assign fq.enq_ready = ready;
  assign fq.freeze    = !ready;
  assign fq.count     = cnt;

`ifdef FETCH_QUEUE_BYPASS_EN
  // While empty the incoming entry is presented directly; it is only stored if decode stalls.
  assign bypass       = empty && fq.enq_valid && fq.deq_ready && !fq.flush;
  assign fq.deq_valid = (!empty || fq.enq_valid) && !fq.flush;
  assign head_e       = empty ? enq_e : mem[head];
`else
  assign bypass       = 1'b0;
  assign fq.deq_valid = !empty && !fq.flush;
  assign head_e       = mem[head];
`endif

  assign fq.deq_pc         = head_e.pc;
  assign fq.deq_instr      = head_e.instr;
  assign fq.deq_pred_pc    = head_e.pred_pc;
  assign fq.deq_pred_taken = head_e.pred_taken;

  assign enq_fire = fq.enq_valid && ready && !fq.flush && !bypass;
  assign deq_fire = fq.deq_valid && fq.deq_ready && !bypass;

  always_ff @(posedge CLK) begin
    if (!nRST || fq.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq_fire) tail <= tail + 1'b1;
      if (deq_fire) head <= head + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; only slots between head and tail are ever observed as valid.
  always_ff @(posedge CLK) begin
    if (enq_fire) mem[tail] <= enq_e;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue: a queue-of-entries reference model drives
// status expectations, and a separate monitor checks every dequeued entry in program order.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int EW    = $bits(fq_entry_t);

  logic CLK;
  logic nRST;

  fetch_queue_if #(.DEPTH(DEPTH)) fq ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .fq   (fq)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit ev, input word_t pc, input bit dr, input bit fl, input bit rst);
    int        sz;
    bit        exp_rdy;
    bit        exp_dv;
    fq_entry_t h;
    fq_entry_t e;
    @(negedge CLK);
    e.pc            = pc;
    e.instr         = $urandom;
    e.pred_pc       = $urandom;
    e.pred_taken    = 1'($urandom_range(0, 1));
    nRST            = !rst;
    fq.enq_valid    = ev;
    fq.enq_pc       = e.pc;
    fq.enq_instr    = e.instr;
    fq.enq_pred_pc  = e.pred_pc;
    fq.enq_pred_taken = e.pred_taken;
    fq.flush        = fl;
    fq.deq_ready    = dr;
    #1;
    sz      = exp_q.size();
    exp_rdy = (sz != DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
    exp_dv  = (sz != 0 || ev) && !fl;
`else
    exp_dv  = (sz != 0) && !fl;
`endif
    check("count",     32'(fq.count),     32'(sz));
    check("enq_ready", 32'(fq.enq_ready), 32'(exp_rdy));
    check("freeze",    32'(fq.freeze),    32'(!exp_rdy));
    check("deq_valid", 32'(fq.deq_valid), 32'(exp_dv));
    if (sz != 0) begin
      h = exp_q[0];
      check("head_pc", fq.deq_pc, h.pc);
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (ev) begin
      check("bypass_pc",    fq.deq_pc,    e.pc);
      check("bypass_instr", fq.deq_instr, e.instr);
    end
`endif
    if (rst || fl) exp_q.delete();
    else if (ev && exp_rdy) exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && exp_q.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    fq_entry_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (nRST && fq.deq_valid && fq.deq_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL deq_unexpected: actual=pc 0x%08h required=no dequeue at %0t", fq.deq_pc, $time);
        end else begin
          e = exp_q.pop_front();
          check("deq_pc",         fq.deq_pc,                e.pc);
          check("deq_instr",      fq.deq_instr,             e.instr);
          check("deq_pred_pc",    fq.deq_pred_pc,           e.pred_pc);
          check("deq_pred_taken", 32'(fq.deq_pred_taken),   32'(e.pred_taken));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    nRST = 1'b0;
    fq.enq_valid = 1'b0;
    fq.enq_pc = '0;
    fq.enq_instr = '0;
    fq.enq_pred_pc = '0;
    fq.enq_pred_taken = 1'b0;
    fq.flush = 1'b0;
    fq.deq_ready = 1'b0;
    repeat (3) @(negedge CLK);
    exp_q.delete();

    // reset state, then first enqueue becomes visible one cycle later
    idle(1);
    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("first_head", fq.deq_pc, 32'h100);

    // fill to full, fifth enqueue rejected
    step(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h108, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h10C, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h110, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("full_head", fq.deq_pc, 32'h100);

    // full with simultaneous dequeue: enqueue still rejected
    step(1'b1, 32'h110, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("after_full_pop_count", 32'(fq.count), 32'd3);
    drain();

    // 10 back-to-back push/pop entries wrapping the pointers
    for (int i = 0; i < 10; i++) step(1'b1, 32'h100 + 32'(4 * i), (i > 0), 1'b0, 1'b0);
    drain();

    // flush with a concurrent enqueue drops everything; redirect enqueues next cycle
    for (int i = 0; i < 3; i++) step(1'b1, 32'h180 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("post_flush_head", fq.deq_pc, 32'h300);
    drain();

    // empty queue with enqueue and dequeue together (zero latency when bypass is built in)
    step(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
    idle(1);
    drain();

    // reset in the middle of traffic
    step(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h504, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 4, $urandom_range(0, 199) == 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
